// File: rtl/ysyx_23060171_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter onto one memory slave port.
// One outstanding transaction, round-robin on ties, response timeout for forward progress.
module ysyx_23060171_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_e;

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic             owner_q;        // 0 = IFU, 1 = LSU
    logic             last_owner_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic             wen_q, err_q;
    logic [7:0]       wmask_q;
    logic [CNT_W-1:0] cnt_q;

    logic grant_lsu, grant_ifu, accept, timeout_hit, owner_rsp_ready;

    // On a tie, the master that did not own the last transaction wins.
    assign grant_lsu       = lsu_req_valid && (!ifu_req_valid || !last_owner_q);
    assign grant_ifu       = ifu_req_valid && !grant_lsu;
    assign accept          = (state_q == IDLE) && (grant_lsu || grant_ifu);
    assign timeout_hit     = TO_EN && (cnt_q == TO_LAST);
    assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (mem_req_ready) state_d = RESP;
            RESP:    if (mem_rsp_valid || timeout_hit) state_d = DELIVER;
            DELIVER: if (owner_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    owner_q      <= grant_lsu;
                    last_owner_q <= grant_lsu;
                    addr_q       <= grant_lsu ? lsu_addr : ifu_addr;
                    wen_q        <= grant_lsu && lsu_wen;
                    wdata_q      <= grant_lsu ? lsu_wdata : '0;
                    wmask_q      <= grant_lsu ? lsu_wmask : '0;
                end
                REQ: if (mem_req_ready) cnt_q <= '0;
                RESP: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (mem_rsp_valid) begin
                        rdata_q <= mem_rdata;
                        err_q   <= mem_rsp_err;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // Request-side ready is masked during reset so nothing handshakes while rst_n is low.
        ifu_req_ready = rst_n && (state_q == IDLE) && grant_ifu;
        lsu_req_ready = rst_n && (state_q == IDLE) && grant_lsu;
        mem_req_valid = (state_q == REQ);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        mem_rsp_ready = (state_q == IDLE) || (state_q == RESP);
        ifu_rsp_valid = (state_q == DELIVER) && !owner_q;
        lsu_rsp_valid = (state_q == DELIVER) && owner_q;
        ifu_rdata     = ifu_rsp_valid ? rdata_q : '0;
        ifu_err       = ifu_rsp_valid && err_q;
        lsu_rdata     = lsu_rsp_valid ? rdata_q : '0;
        lsu_err       = lsu_rsp_valid && err_q;
        busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_ysyx_23060171_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: table of single transactions plus
// hand-built round-robin, backpressure, timeout and mid-transaction reset sequences.
module tb_ysyx_23060171_mem_arbiter;

    logic        clk, rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy;

    ysyx_23060171_mem_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .mem_rsp_err(mem_rsp_err), .busy(busy)
    );

    typedef struct {
        bit          is_lsu;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          req_wait;
        bit          silent;
        bit          serr;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_wen;
        logic [7:0]  exp_wmask;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          is_lsu;
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Slave controls
    int   s_req_wait = 0;
    bit   s_silent   = 0;
    bit   s_err      = 0;
    bit   stray_seen = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Slave model: updates outputs 1 time unit after each edge.
    initial begin
        bit          req_hs, rsp_hs, pending;
        int          wcnt;
        logic [31:0] paddr;
        req_hs = 0; rsp_hs = 0; pending = 0; wcnt = 0; paddr = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pending = 0; wcnt = 0; req_hs = 0; rsp_hs = 0;
                mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
            end else begin
                if (rsp_hs) pending = 0;
                if (req_hs) pending = 1;
                if (mem_req_valid) begin
                    mem_req_ready = (wcnt >= s_req_wait);
                    wcnt++;
                end else begin
                    mem_req_ready = 0;
                    wcnt = 0;
                end
                mem_rsp_valid = pending && !s_silent;
                mem_rdata     = mem_rsp_valid ? slave_data(paddr) : '0;
                mem_rsp_err   = mem_rsp_valid && s_err;
                req_hs = mem_req_valid && mem_req_ready;
                if (req_hs) paddr = mem_addr;
                rsp_hs = mem_rsp_valid && mem_rsp_ready;
                if (rsp_hs && !busy) stray_seen = 1;
            end
        end
    end

    // Response monitor: pops the scoreboard on every master response handshake.
    initial begin
        forever begin
            @(posedge clk); #4;
            if (rst_n) begin
                check("rsp_onehot", {63'd0, ifu_rsp_valid && lsu_rsp_valid}, 64'd0);
                if (ifu_rsp_valid || lsu_rsp_valid) begin
                    bit is_l;
                    is_l = lsu_rsp_valid;
                    check("rsp_expected", {63'd0, sb.size() != 0}, 64'd1);
                    if (is_l) check("nonowner_zero", {31'd0, ifu_err, ifu_rdata}, 64'd0);
                    else      check("nonowner_zero", {31'd0, lsu_err, lsu_rdata}, 64'd0);
                    if (sb.size() != 0 && (is_l ? lsu_rsp_ready : ifu_rsp_ready)) begin
                        rsp_t e;
                        e = sb.pop_front();
                        check("rsp_owner", {63'd0, is_l}, {63'd0, e.is_lsu});
                        check("rsp_rdata", {32'd0, is_l ? lsu_rdata : ifu_rdata}, {32'd0, e.rdata});
                        check("rsp_err", {63'd0, is_l ? lsu_err : ifu_err}, {63'd0, e.err});
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    function automatic vec_t mkv(input bit l, input logic [31:0] a, input bit w, input logic [31:0] d,
                                 input logic [7:0] m, input int rw, input bit sil, input bit se);
        vec_t v;
        v.is_lsu = l; v.addr = a; v.wen = w; v.wdata = d; v.wmask = m;
        v.req_wait = rw; v.silent = sil; v.serr = se;
        v.exp_rdata = sil ? 32'h0 : slave_data(a);
        v.exp_err   = sil || se;
        v.exp_wen   = l && w;
        v.exp_wmask = l ? m : 8'h00;
        v.exp_lat   = (sil ? 10 : 3) + rw;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 0;
        ifu_req_valid = 1; lsu_req_valid = 0;
        ifu_addr = '0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        s_req_wait = 0; s_silent = 0; s_err = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_req_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        check("rst_valids", {61'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        check("rst_mem_fields", {23'd0, mem_wen, mem_wmask, mem_addr}, 64'd0);
        check("rst_mem_rsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
        ifu_req_valid = 0;
        @(posedge clk); #2;
        rst_n = 1;
    endtask

    task automatic do_txn(input vec_t v);
        bit got_hs, got_rsp;
        int first_mrv;
        s_req_wait = v.req_wait; s_silent = v.silent; s_err = v.serr;
        got_hs = 0;
        for (int k = 0; k < 20 && !got_hs; k++) begin
            step();
            if (v.is_lsu) begin
                lsu_req_valid = 1; lsu_addr = v.addr; lsu_wen = v.wen;
                lsu_wdata = v.wdata; lsu_wmask = v.wmask;
            end else begin
                ifu_req_valid = 1; ifu_addr = v.addr;
            end
            #1;
            if (v.is_lsu ? lsu_req_ready : ifu_req_ready) got_hs = 1;
        end
        check("req_handshake", {63'd0, got_hs}, 64'd1);
        if (!got_hs) return;
        sb.push_back('{v.is_lsu, v.exp_rdata, v.exp_err});
        got_rsp = 0; first_mrv = -1;
        for (int k = 1; k <= 40 && !got_rsp; k++) begin
            step();
            ifu_req_valid = 0; lsu_req_valid = 0;
            #1;
            if (mem_req_valid) begin
                if (first_mrv < 0) first_mrv = k;
                check("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
                check("mem_wen", {63'd0, mem_wen}, {63'd0, v.exp_wen});
                check("mem_wmask", {56'd0, mem_wmask}, {56'd0, v.exp_wmask});
                if (v.exp_wen) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
            end
            if (v.is_lsu ? lsu_rsp_valid : ifu_rsp_valid) begin
                got_rsp = 1;
                check("rsp_latency", 64'(k), 64'(v.exp_lat));
            end
        end
        check("mem_req_start", 64'(first_mrv), 64'd1);
        check("rsp_arrived", {63'd0, got_rsp}, 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = mkv(0, 32'h8000_0000, 0, 32'h0,         8'h00, 0, 0, 0);
        vecs[1] = mkv(1, 32'h8000_1004, 1, 32'hDEAD_BEEF, 8'h0C, 5, 0, 0);
        vecs[2] = mkv(1, 32'h8000_2000, 0, 32'h0,         8'h00, 0, 0, 0);
        vecs[3] = mkv(0, 32'h8000_0004, 0, 32'h0,         8'h00, 0, 0, 1);
        vecs[4] = mkv(1, 32'h8000_3000, 1, 32'h1234_5678, 8'h01, 2, 0, 0);
        vecs[5] = mkv(1, 32'h8000_5000, 0, 32'h0,         8'h00, 0, 1, 0);

        do_reset();

        // Round-robin: both masters valid from the first cycle after reset.
        begin
            bit first;
            first = 1;
            ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_0200; lsu_wen = 0;
            ifu_req_valid = 1; lsu_req_valid = 1;
            for (int g = 0; g < 4; g++) begin
                bit got, exp_l;
                got = 0;
                exp_l = (g % 2 == 0);
                for (int k = 0; k < 30 && !got; k++) begin
                    if (!first) step();
                    first = 0;
                    #1;
                    if (ifu_req_ready || lsu_req_ready) begin
                        got = 1;
                        check("rr_grant_lsu", {63'd0, lsu_req_ready}, {63'd0, exp_l});
                        check("rr_grant_ifu", {63'd0, ifu_req_ready}, {63'd0, !exp_l});
                        sb.push_back('{exp_l, slave_data(exp_l ? 32'h8000_0200 : 32'h8000_0100), 1'b0});
                    end
                end
                check("rr_granted", {63'd0, got}, 64'd1);
                step(); #1;
                check("rr_mem_valid", {63'd0, mem_req_valid}, 64'd1);
                check("rr_mem_addr", {32'd0, mem_addr}, {32'd0, exp_l ? 32'h8000_0200 : 32'h8000_0100});
            end
            step();
            ifu_req_valid = 0; lsu_req_valid = 0;
            for (int k = 0; k < 20 && sb.size() != 0; k++) step();
            step();
            check("rr_drained", 64'(sb.size()), 64'd0);
        end

        do_reset();

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
            if (vecs[i].silent) begin
                // Late response after timeout must be swallowed in IDLE.
                s_silent = 0;
                stray_seen = 0;
                for (int k = 0; k < 5; k++) begin
                    step(); #1;
                    check("no_extra_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
                end
                check("stray_accepted", {63'd0, stray_seen}, 64'd1);
                check("busy_after_stray", {63'd0, busy}, 64'd0);
            end
        end
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        check("table_drained", 64'(sb.size()), 64'd0);

        // LSU response backpressure with an IFU request waiting.
        begin
            bit seen;
            s_req_wait = 0; s_silent = 0; s_err = 0;
            step();
            lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 0; lsu_rsp_ready = 0;
            #1;
            check("bp_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
            sb.push_back('{1'b1, slave_data(32'h8000_4000), 1'b0});
            step();
            lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
            #1;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                check("bp_ifu_blocked", {63'd0, ifu_req_ready}, 64'd0);
                if (lsu_rsp_valid) seen = 1;
                else begin step(); #1; end
            end
            check("bp_rsp_seen", {63'd0, seen}, 64'd1);
            for (int k = 0; k < 3; k++) begin
                if (k > 0) begin step(); #1; end
                check("bp_valid_held", {63'd0, lsu_rsp_valid}, 64'd1);
                check("bp_rdata_held", {32'd0, lsu_rdata}, {32'd0, slave_data(32'h8000_4000)});
                check("bp_ifu_blocked_d", {63'd0, ifu_req_ready}, 64'd0);
            end
            step();
            lsu_rsp_ready = 1;
            #1;
            check("bp_ifu_blocked_hs", {63'd0, ifu_req_ready}, 64'd0);
            step(); #1;
            check("bp_ifu_granted", {63'd0, ifu_req_ready}, 64'd1);
            sb.push_back('{1'b0, slave_data(32'h8000_0040), 1'b0});
            step();
            ifu_req_valid = 0;
            for (int k = 0; k < 10 && sb.size() != 0; k++) step();
            check("bp_drained", 64'(sb.size()), 64'd0);
        end

        // Asynchronous reset while waiting in RESP.
        begin
            s_silent = 1;
            step();
            lsu_req_valid = 1; lsu_addr = 32'h8000_6000; lsu_wen = 1;
            lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 8'hF0;
            #1;
            check("ar_req_ready", {63'd0, lsu_req_ready}, 64'd1);
            step(); lsu_req_valid = 0;
            step(); step(); #1;
            check("ar_busy_before", {63'd0, busy}, 64'd1);
            #2;
            rst_n = 0;
            #1;
            check("ar_busy", {63'd0, busy}, 64'd0);
            check("ar_valids", {61'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
            check("ar_fields", {23'd0, mem_wen, mem_wmask, mem_addr}, 64'd0);
            check("ar_wdata", {32'd0, mem_wdata}, 64'd0);
            check("ar_rsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
            repeat (2) @(posedge clk);
            #2;
            s_silent = 0;
            rst_n = 1;
            do_txn(mkv(0, 32'h8000_0000, 0, 32'h0, 8'h00, 0, 0, 0));
            for (int k = 0; k < 10 && sb.size() != 0; k++) step();
            check("ar_drained", 64'(sb.size()), 64'd0);
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060171_mem_arbiter.md
Name: ysyx_23060171_mem_arbiter

Overview:
- Shares one data-memory slave port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Captures one request at a time and drives it to memory. It then waits for the memory response and returns that response to the requester that issued it.
- Simultaneous requests are resolved round-robin.
- A response timeout guarantees forward progress when the slave never answers.

Parameters:
- TIMEOUT, 255: cycles allowed in RESP before an error is returned. 0 disables the timeout.
- CNT_W, 16: width of the timeout counter. TIMEOUT must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  32  IFU address
- ifu_rsp_valid  out  1  IFU response valid
- ifu_rsp_ready  in  1  IFU accepts response
- ifu_rdata  out  32  IFU read data
- ifu_err  out  1  IFU response error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  32  LSU word-aligned address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  32  store data
- lsu_wmask  in  8  byte write mask, already shifted to the byte lane
- lsu_rsp_valid  out  1  LSU response valid
- lsu_rsp_ready  in  1  LSU accepts response
- lsu_rdata  out  32  LSU raw read word
- lsu_err  out  1  LSU response error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  memory address
- mem_wen  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_wmask  out  8  memory write mask
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_ready  out  1  arbiter accepts response
- mem_rdata  in  32  memory read data
- mem_rsp_err  in  1  memory error
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, all valid/ready outputs 0 except mem_rsp_ready (see IDLE), all data/address outputs 0, last_owner=IFU, counter=0.
  - Reset asserted mid-transaction discards the transaction, with no response to either master.
- States are IDLE, REQ, RESP, DELIVER.
- IDLE:
  - Arbitration is combinational.
    - Only one requester valid: that requester wins.
    - Both valid: the requester that was not last_owner wins, so the first tie after reset goes to the LSU.
  - The winner's req_ready=1. The loser's req_ready=0.
  - On handshake, the arbiter registers addr/wen/wdata/wmask and owner. IFU requests are captured with wen=0 and wmask=0.
  - last_owner is updated to the winner. Transition to REQ.
  - mem_rsp_ready=1 in IDLE. Any stray mem_rsp beat is accepted and discarded.
- REQ:
  - mem_req_valid=1 with the registered fields held stable.
  - On mem_req_ready=1, go to RESP and clear the counter.
  - There is no timeout in REQ.
- RESP:
  - mem_rsp_ready=1.
  - On mem_rsp_valid: register rdata and err=mem_rsp_err, then go to DELIVER.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without a response: register rdata=0 and err=1, then go to DELIVER.
  - mem_rsp_valid on the same cycle as expiry is a normal response; the response wins.
- DELIVER:
  - The owner's rsp_valid=1 with registered rdata/err.
  - The non-owner's rsp_valid=0, and its rdata/err are driven 0.
  - mem_rsp_ready=0.
  - On owner rsp_ready=1, go to IDLE. A new request is accepted in IDLE on the following cycle.
- Latency with a zero-wait slave and always-ready master:
  - Master handshake at cycle N.
  - mem_req_valid at N+1.
  - Response accepted at N+2.
  - Master rsp_valid at N+3.
  - Throughput is one transaction per 4 cycles.
- Exactly one outstanding transaction at a time. Request-side inputs are ignored outside IDLE.
- A store returns a response, with rdata as supplied by the slave. The LSU ignores it.

Test Plan:
- Single IFU read to addr 0x80000000; zero-wait slave returns 0x00000413 -> ifu_rsp_valid at cycle N+3 with ifu_rdata=0x00000413, ifu_err=0; lsu_rsp_valid stays 0.
- IFU and LSU both valid in the first cycle after reset, repeated 4 times -> grants in the order LSU, IFU, LSU, IFU. Each mem_addr matches its requester.
- LSU store addr 0x80001004, wdata 0xDEADBEEF, wmask 0x0C -> mem_wen=1, mem_wmask=0x0C, mem_wdata=0xDEADBEEF. All three are held until mem_req_ready, even with mem_req_ready delayed 5 cycles.
- TIMEOUT=8 and slave never responds -> lsu_rsp_valid with lsu_err=1 and lsu_rdata=0 exactly 8 cycles after entering RESP. A late mem_rsp_valid is later dropped in IDLE and no extra response is produced.
- lsu_rsp_ready held 0 for 3 cycles in DELIVER -> lsu_rsp_valid and data stay stable, and a pending ifu_req_valid sees ifu_req_ready=0 until after the LSU response handshake.
- rst_n pulsed low during RESP -> all outputs return to reset values immediately (asynchronously), with no response delivered. The next request completes normally.
